// File: rtl/adder_accumulator.sv
`default_nettype none
// ============================================================================
// adder_accumulator: signed packet accumulator with scaled, range-fitted output
// Revision: 1.0
// ============================================================================
module adder_accumulator #(
  parameter int IN_WIDTH    = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_SCALE   = 0,
  parameter int SATURATE    = 1,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   arst_n_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_overflow
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0]        OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]        OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [0:0]                   state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [COUNT_WIDTH-1:0]       count;
  logic                         sticky_ovf;

  logic                         accept;
  logic signed [ACC_WIDTH-1:0]  base;
  logic signed [ACC_WIDTH-1:0]  samp;
  logic signed [ACC_WIDTH-1:0]  raw;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic                         add_ovf;
  logic                         ovf_next;
  logic [COUNT_WIDTH-1:0]       cnt_base;
  logic [COUNT_WIDTH-1:0]       cnt_next;
  logic [OUT_WIDTH-1:0]         fit_data;
  logic                         fit_loss;

  assign out_valid = (state == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign samp = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

  always_comb begin
    base     = in_first ? '0 : acc;
    raw      = base + samp;
    add_ovf  = (base[ACC_WIDTH-1] == samp[ACC_WIDTH-1]) &&
               (raw[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    sum      = raw;
    if (add_ovf && (SATURATE != 0))
      sum = base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    ovf_next = (in_first ? 1'b0 : sticky_ovf) | add_ovf;
    cnt_base = in_first ? '0 : count;
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + COUNT_WIDTH'(1);
    shifted  = sum >>> OUT_SCALE;
  end

  // The result fits when every bit above the output sign bit matches it.
  if (ACC_WIDTH > OUT_WIDTH) begin : g_fit_narrow
    logic [ACC_WIDTH-OUT_WIDTH:0] upper;
    assign upper    = shifted[ACC_WIDTH-1:OUT_WIDTH-1];
    assign fit_loss = !((&upper) || !(|upper));
    assign fit_data = (fit_loss && (SATURATE != 0))
                    ? (shifted[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX)
                    : shifted[OUT_WIDTH-1:0];
  end else begin : g_fit_wide
    assign fit_loss = 1'b0;
    assign fit_data = OUT_WIDTH'(shifted);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state        <= ACCUM;
      acc          <= '0;
      count        <= '0;
      sticky_ovf   <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (accept && in_last) begin
        acc          <= '0;
        count        <= '0;
        sticky_ovf   <= 1'b0;
        out_data     <= fit_data;
        out_count    <= cnt_next;
        out_overflow <= ovf_next | fit_loss;
        state        <= HOLD;
      end else begin
        if (accept) begin
          acc        <= sum;
          count      <= cnt_next;
          sticky_ovf <= ovf_next;
        end
        if ((state == HOLD) && out_ready)
          state <= ACCUM;
      end
    end
  end

endmodule
`default_nettype wire
